intr_entry_ctrl: RTL and testbench
==================================

Name: intr_entry_ctrl

Overview:
- Sequencer between the interrupt encoder/SPR file and the core pipeline.
- On a latched exception code it drains the pipeline, saves context (SRR0, SRR1, DEAR) through one SPR write port, and masks MSR.
- It then redirects fetch to the vector address and pulses ack, which clears the encoder.
- It also executes rfi: restores MSR from SRR1 and redirects to SRR0.

Parameters:
EXC_W, 4, exception code width
MSR_CLR_MASK, 32'h0000_C030, MSR bits cleared on entry (big-endian bits EE 16, PR 17, IS 26, DS 27)
DRAIN_MAX, 15, max cycles waiting for pipe_drained before forcing progress

Ports:
clk  in  1  clock
rst  in  1  reset
excep_code  in  EXC_W  latched code: 0 NONE, 1 DSI, 2 ISI, 3 DMISS, 4 IMISS, 5 TRAP, 6 PRIV, 7 ILLE, 8 SC, 9 DEV0, 10 DEV1
intr_entry_addr  in  32  vector address for excep_code
excep_pc  in  32  PC of faulting/syscall instruction
data_ea  in  32  effective address of faulting data access
msr_in  in  32  current MSR
rfi_req  in  1  rfi reached execute; level, held until rfi_done
pipe_drained  in  1  no older instruction in flight
spr_rd  in  32  SPR read data (combinational on spr_raddr)
spr_raddr  out  10  SPR read address
spr_waddr  out  10  SPR write address
spr_wd  out  32  SPR write data
spr_wr  out  1  SPR write strobe
msr_wr  out  1  MSR write strobe
msr_wd  out  32  MSR write data
flush  out  1  kill younger instructions
stall  out  1  freeze fetch/issue
npc_valid  out  1  one-cycle redirect
npc  out  32  redirect target
ack  out  1  one-cycle exception acknowledge to encoder
rfi_done  out  1  one-cycle rfi completion
busy  out  1  state != IDLE

Behaviour:
- Reset: rst is asynchronous, active-low. It forces IDLE, drain counter 0, and all outputs 0 (spr_raddr = 0, npc = 0).
- All outputs are registered or decoded from state only (Moore). There is no combinational path from inputs to outputs except spr_wd/npc/msr_wd data, which are sampled from inputs in their state.
- SPR numbers: SRR0 = 26, SRR1 = 27, DEAR = 61.
- States: IDLE, DRAIN, SV_SRR0, SV_SRR1, SV_DEAR, SET_MSR, REDIR, ACK, R_DRAIN, R_MSR, R_PC.
- IDLE:
  - excep_code != 0 goes to DRAIN and captures code, excep_pc, data_ea, msr_in into internal registers.
  - Otherwise rfi_req goes to R_DRAIN.
  - Exception wins when both are present.
- DRAIN / R_DRAIN:
  - stall = 1 and flush = 1.
  - Advance when pipe_drained = 1 or the counter reaches DRAIN_MAX.
  - The counter clears on exit.
- SV_SRR0:
  - spr_wr = 1, spr_waddr = 26.
  - spr_wd = captured pc + 4 if code = SC, else captured pc. The add wraps mod 2^32.
- SV_SRR1: spr_wr = 1, waddr 27, wd = captured msr.
- SV_DEAR:
  - Entered only for DSI or DMISS; other codes skip to SET_MSR.
  - spr_wr = 1, waddr 61, wd = captured data_ea.
- SET_MSR: msr_wr = 1, msr_wd = captured msr & ~MSR_CLR_MASK.
- REDIR: npc_valid = 1, npc = intr_entry_addr, sampled in that cycle.
- ACK: ack = 1 for exactly one cycle, then IDLE.
  - The encoder returns code 0 next cycle.
  - The controller does not re-accept the code while it is nonzero in the cycle after ACK. Re-entry only happens from IDLE on a fresh nonzero code, and requires ≥1 IDLE cycle.
- R_MSR: spr_raddr = 27, msr_wr = 1, msr_wd = spr_rd.
- R_PC: spr_raddr = 26, npc_valid = 1, npc = spr_rd with bits [30:31] forced 0, rfi_done = 1, then IDLE.
- stall = 1 in every non-IDLE state. flush = 1 only in the drain states.
- excep_code or rfi_req changes during a sequence are ignored. Captured values are used.
- Exception latency:
  - Code seen in IDLE at cycle 0, drained at cycle 1: ack at cycle 6 (non-DSI) or cycle 7 (DSI/DMISS).
- rfi latency: rfi_done at cycle 3 when drained immediately.
- Asserting reset mid-sequence aborts with no further writes.

Test Plan:
- excep_code = 8 (SC), excep_pc = 0x0000_1000, msr_in = 0x0000_C000, pipe_drained = 1:
  - SRR0 write 0x0000_1004, SRR1 write 0x0000_C000, no DEAR write.
  - msr_wd = 0x0000_0000; npc = intr_entry_addr; ack one cycle at cycle 6.
- excep_code = 1 (DSI), data_ea = 0xDEAD_BEE0, excep_pc = 0x200:
  - SRR0 = 0x200, then DEAR write 0xDEAD_BEE0 at waddr 61; ack at cycle 7.
- pipe_drained held low:
  - Controller stays in DRAIN with flush = 1 for 15 cycles, then proceeds.
  - Raising pipe_drained at cycle 3 instead advances on cycle 4.
- rfi_req with SRR1 = 0x0000_8000, SRR0 = 0x0000_3003:
  - msr_wd = 0x0000_8000, npc = 0x0000_3000, rfi_done one cycle.
- rfi_req and excep_code = 5 in the same IDLE cycle:
  - Exception sequence runs first; after ack, rfi runs to completion.
- Reset pulled low during SV_SRR1:
  - All outputs 0 immediately (asynchronous), no msr_wr.
  - After release, state is IDLE and busy = 0.

Source files
------------

// File: rtl/intr_entry_ctrl.sv
`timescale 1ns/1ps
// intr_entry_ctrl
// Sequences interrupt entry and rfi between the interrupt encoder, the SPR
// file and the core pipeline. Entry drains the pipe, saves SRR0/SRR1 (and
// DEAR for data-side faults) through the single SPR write port, masks MSR,
// redirects fetch to the vector and acknowledges the encoder. rfi restores
// MSR from SRR1 and redirects to SRR0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a nonzero exception code or rfi_req
// DRAIN    | exception: stall+flush until pipe drained or drain timeout
// SV_SRR0  | write return PC (pc+4 for SC) to SRR0
// SV_SRR1  | write captured MSR to SRR1
// SV_DEAR  | write faulting data EA to DEAR (DSI/DMISS only)
// SET_MSR  | write MSR with entry bits cleared
// REDIR    | redirect fetch to intr_entry_addr
// ACK      | one-cycle acknowledge to the encoder
// R_DRAIN  | rfi: stall+flush until pipe drained or drain timeout
// R_MSR    | MSR <- SRR1
// R_PC     | redirect to SRR0 (word aligned), signal rfi_done
module intr_entry_ctrl #(
    parameter int          EXC_W        = 4,
    parameter logic [31:0] MSR_CLR_MASK = 32'h0000_C030,
    parameter int          DRAIN_MAX    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [EXC_W-1:0] excep_code,
    input  logic [31:0]      intr_entry_addr,
    input  logic [31:0]      excep_pc,
    input  logic [31:0]      data_ea,
    input  logic [31:0]      msr_in,
    input  logic             rfi_req,
    input  logic             pipe_drained,
    input  logic [31:0]      spr_rd,
    output logic [9:0]       spr_raddr,
    output logic [9:0]       spr_waddr,
    output logic [31:0]      spr_wd,
    output logic             spr_wr,
    output logic             msr_wr,
    output logic [31:0]      msr_wd,
    output logic             flush,
    output logic             stall,
    output logic             npc_valid,
    output logic [31:0]      npc,
    output logic             ack,
    output logic             rfi_done,
    output logic             busy
);

    localparam logic [9:0] SPR_SRR0 = 10'd26;
    localparam logic [9:0] SPR_SRR1 = 10'd27;
    localparam logic [9:0] SPR_DEAR = 10'd61;

    localparam logic [EXC_W-1:0] CODE_NONE  = EXC_W'(0);
    localparam logic [EXC_W-1:0] CODE_DSI   = EXC_W'(1);
    localparam logic [EXC_W-1:0] CODE_DMISS = EXC_W'(3);
    localparam logic [EXC_W-1:0] CODE_SC    = EXC_W'(8);

    localparam int                CNT_W      = $clog2(DRAIN_MAX + 1);
    // The drain state is left on the DRAIN_MAX-th cycle spent in it.
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DRAIN   = 4'd1,
        ST_SV_SRR0 = 4'd2,
        ST_SV_SRR1 = 4'd3,
        ST_SV_DEAR = 4'd4,
        ST_SET_MSR = 4'd5,
        ST_REDIR   = 4'd6,
        ST_ACK     = 4'd7,
        ST_R_DRAIN = 4'd8,
        ST_R_MSR   = 4'd9,
        ST_R_PC    = 4'd10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic [EXC_W-1:0] code_q;
    logic [31:0]      pc_q;
    logic [31:0]      ea_q;
    logic [31:0]      msr_q;
    logic             post_ack_q;

    logic in_drain;
    logic drain_done;
    logic take_exc;
    logic need_dear;

    assign in_drain   = (state_q == ST_DRAIN) || (state_q == ST_R_DRAIN);
    assign drain_done = pipe_drained || (drain_cnt_q == DRAIN_LAST);
    // The encoder only clears its code the cycle after ack, so that stale
    // code must not start a second entry.
    assign take_exc   = (excep_code != CODE_NONE) && !post_ack_q;
    assign need_dear  = (code_q == CODE_DSI) || (code_q == CODE_DMISS);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain timeout counter, counts cycles spent in a drain state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt_q <= '0;
        end else if (in_drain && !drain_done) begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
        end else begin
            drain_cnt_q <= '0;
        end
    end

    // Capture the exception context when the entry is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q <= '0;
            pc_q   <= '0;
            ea_q   <= '0;
            msr_q  <= '0;
        end else if ((state_q == ST_IDLE) && take_exc) begin
            code_q <= excep_code;
            pc_q   <= excep_pc;
            ea_q   <= data_ea;
            msr_q  <= msr_in;
        end
    end

    // Marks the IDLE cycle that directly follows ACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            post_ack_q <= 1'b0;
        end else begin
            post_ack_q <= (state_q == ST_ACK);
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_exc) begin
                    state_d = ST_DRAIN;
                end else if (rfi_req) begin
                    state_d = ST_R_DRAIN;
                end
            end
            ST_DRAIN:   if (drain_done) state_d = ST_SV_SRR0;
            ST_SV_SRR0: state_d = ST_SV_SRR1;
            ST_SV_SRR1: state_d = need_dear ? ST_SV_DEAR : ST_SET_MSR;
            ST_SV_DEAR: state_d = ST_SET_MSR;
            ST_SET_MSR: state_d = ST_REDIR;
            ST_REDIR:   state_d = ST_ACK;
            ST_ACK:     state_d = ST_IDLE;
            ST_R_DRAIN: if (drain_done) state_d = ST_R_MSR;
            ST_R_MSR:   state_d = ST_R_PC;
            ST_R_PC:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state and captured context.
    always_comb begin
        spr_raddr = '0;
        spr_waddr = '0;
        spr_wd    = '0;
        spr_wr    = 1'b0;
        msr_wr    = 1'b0;
        msr_wd    = '0;
        flush     = in_drain;
        stall     = (state_q != ST_IDLE);
        npc_valid = 1'b0;
        npc       = '0;
        ack       = 1'b0;
        rfi_done  = 1'b0;
        case (state_q)
            ST_SV_SRR0: begin
                spr_wr    = 1'b1;
                spr_waddr = SPR_SRR0;
                spr_wd    = (code_q == CODE_SC) ? (pc_q + 32'd4) : pc_q;
            end
            ST_SV_SRR1: begin
                spr_wr    = 1'b1;
                spr_waddr = SPR_SRR1;
                spr_wd    = msr_q;
            end
            ST_SV_DEAR: begin
                spr_wr    = 1'b1;
                spr_waddr = SPR_DEAR;
                spr_wd    = ea_q;
            end
            ST_SET_MSR: begin
                msr_wr = 1'b1;
                msr_wd = msr_q & ~MSR_CLR_MASK;
            end
            ST_REDIR: begin
                npc_valid = 1'b1;
                npc       = intr_entry_addr;
            end
            ST_ACK: begin
                ack = 1'b1;
            end
            ST_R_MSR: begin
                spr_raddr = SPR_SRR1;
                msr_wr    = 1'b1;
                msr_wd    = spr_rd;
            end
            ST_R_PC: begin
                spr_raddr = SPR_SRR0;
                npc_valid = 1'b1;
                npc       = {spr_rd[31:2], 2'b00};
                rfi_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_intr_entry_ctrl.sv
`timescale 1ns/1ps
// Bench for intr_entry_ctrl: directed and random entry/rfi sequences checked
// against expected latency and data derived from the request inputs.
module tb_intr_entry_ctrl;

    localparam logic [31:0] CLR_MASK  = 32'h0000_C030;
    localparam int          DRAIN_MAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  excep_code;
    logic [31:0] intr_entry_addr;
    logic [31:0] excep_pc;
    logic [31:0] data_ea;
    logic [31:0] msr_in;
    logic        rfi_req;
    logic        pipe_drained;
    logic [31:0] spr_rd;
    logic [9:0]  spr_raddr;
    logic [9:0]  spr_waddr;
    logic [31:0] spr_wd;
    logic        spr_wr;
    logic        msr_wr;
    logic [31:0] msr_wd;
    logic        flush;
    logic        stall;
    logic        npc_valid;
    logic [31:0] npc;
    logic        ack;
    logic        rfi_done;
    logic        busy;

    intr_entry_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .excep_code      (excep_code),
        .intr_entry_addr (intr_entry_addr),
        .excep_pc        (excep_pc),
        .data_ea         (data_ea),
        .msr_in          (msr_in),
        .rfi_req         (rfi_req),
        .pipe_drained    (pipe_drained),
        .spr_rd          (spr_rd),
        .spr_raddr       (spr_raddr),
        .spr_waddr       (spr_waddr),
        .spr_wd          (spr_wd),
        .spr_wr          (spr_wr),
        .msr_wr          (msr_wr),
        .msr_wd          (msr_wd),
        .flush           (flush),
        .stall           (stall),
        .npc_valid       (npc_valid),
        .npc             (npc),
        .ack             (ack),
        .rfi_done        (rfi_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // SPR file stand-in: written by the DUT, or preset by the bench.
    logic [31:0] spr_mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_a  = '0;
    logic [31:0] pre_d  = '0;
    always @(posedge clk) begin
        if (pre_we) spr_mem[pre_a] <= pre_d;
        else if (spr_wr) spr_mem[spr_waddr] <= spr_wd;
    end
    assign spr_rd = spr_mem[spr_raddr];

    typedef struct {
        int          cyc;
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    int          n_pass = 0;
    int          n_total = 0;
    wr_t         wq[$];
    int          ack_n, ack_cyc, msr_n, msr_cyc, npc_n, npc_cyc, done_n, done_cyc;
    int          flush_n, stall_bad;
    logic [31:0] msr_v, npc_v;
    logic [31:0] ent_at [0:63];
    // Model view of what SRR0/SRR1 should currently hold.
    logic [31:0] m_srr0, m_srr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_rec();
        wq.delete();
        ack_n = 0; ack_cyc = -1; msr_n = 0; msr_cyc = -1; npc_n = 0; npc_cyc = -1;
        done_n = 0; done_cyc = -1; flush_n = 0; stall_bad = 0;
        msr_v = '0; npc_v = '0;
    endtask

    task automatic sample(input int c);
        if (spr_wr) wq.push_back('{c, spr_waddr, spr_wd});
        if (msr_wr) begin msr_n++; msr_v = msr_wd; msr_cyc = c; end
        if (npc_valid) begin npc_n++; npc_v = npc; npc_cyc = c; end
        if (ack) begin ack_n++; ack_cyc = c; end
        if (rfi_done) begin done_n++; done_cyc = c; end
        if (flush) flush_n++;
        if (stall !== busy) stall_bad++;
    endtask

    // One cycle of an entry sequence: cycle 0 presents the real request,
    // later cycles scramble the request inputs, which must be ignored.
    task automatic exc_cycle(input int c, input logic [3:0] code, input logic [31:0] pc,
                             input logic [31:0] ea, input logic [31:0] msr,
                             input int raise, input logic hold_rfi);
        @(posedge clk); #1;
        if (c == 0) begin
            excep_code = code; excep_pc = pc; data_ea = ea; msr_in = msr;
        end else begin
            excep_code = 4'($urandom_range(1, 10));
            excep_pc = $urandom; data_ea = $urandom; msr_in = $urandom;
        end
        rfi_req = hold_rfi;
        pipe_drained = (c >= raise);
        intr_entry_addr = $urandom;
        ent_at[c] = intr_entry_addr;
        @(negedge clk);
        sample(c);
    endtask

    function automatic int drain_len(input int raise);
        if (raise < 1) return 1;
        if (raise > DRAIN_MAX) return DRAIN_MAX;
        return raise;
    endfunction

    task automatic run_exc(input string tag, input logic [3:0] code, input logic [31:0] pc,
                           input logic [31:0] ea, input logic [31:0] msr,
                           input int raise, input logic hold_rfi);
        int          l, dear, n_exp;
        logic [9:0]  ea_x [0:2];
        logic [31:0] ed_x [0:2];
        logic        seen;
        clear_rec();
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            exc_cycle(c, code, pc, ea, msr, raise, hold_rfi);
            if (ack_n > 0) seen = 1'b1;
        end
        l     = drain_len(raise);
        dear  = (code == 4'd1 || code == 4'd3) ? 1 : 0;
        n_exp = 2 + dear;
        ea_x[0] = 10'd26; ed_x[0] = (code == 4'd8) ? pc + 32'd4 : pc;
        ea_x[1] = 10'd27; ed_x[1] = msr;
        ea_x[2] = 10'd61; ed_x[2] = ea;
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
        chk({tag, "_ack_cyc"}, ack_cyc, l + 5 + dear);
        chk({tag, "_wr_count"}, wq.size(), n_exp);
        for (int i = 0; i < n_exp && i < wq.size(); i++) begin
            chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wq[i].a), 32'(ea_x[i]));
            chk($sformatf("%s_wr%0d_data", tag, i), wq[i].d, ed_x[i]);
            chk($sformatf("%s_wr%0d_cyc", tag, i), wq[i].cyc, l + 1 + i);
        end
        chk({tag, "_msr_n"}, msr_n, 1);
        chk({tag, "_msr_wd"}, msr_v, msr & ~CLR_MASK);
        chk({tag, "_msr_cyc"}, msr_cyc, l + 3 + dear);
        chk({tag, "_npc_n"}, npc_n, 1);
        chk({tag, "_npc"}, npc_v, ent_at[l + 4 + dear]);
        chk({tag, "_flush_n"}, flush_n, l);
        chk({tag, "_stall"}, stall_bad, 0);
        chk({tag, "_no_rfi_done"}, done_n, 0);
        m_srr0 = ed_x[0];
        m_srr1 = msr;
    endtask

    // Two cycles after an ack: the stale code is still present in the first,
    // and must not restart the sequence.
    task automatic post_idle(input string tag);
        @(posedge clk); #1;
        excep_code = 4'($urandom_range(1, 10)); rfi_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_one_cycle"}, 32'(ack), 32'd0);
        chk({tag, "_idle_after_ack"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        excep_code = 4'd0;
        @(negedge clk);
        chk({tag, "_no_reentry"}, 32'(busy), 32'd0);
    endtask

    task automatic run_rfi(input string tag, input int raise);
        int   l;
        logic seen;
        clear_rec();
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk); #1;
            excep_code = (c == 0) ? 4'd0 : 4'($urandom_range(1, 10));
            excep_pc = $urandom; data_ea = $urandom; msr_in = $urandom;
            intr_entry_addr = $urandom;
            rfi_req = 1'b1;
            pipe_drained = (c >= raise);
            @(negedge clk);
            sample(c);
            if (done_n > 0) seen = 1'b1;
        end
        l = drain_len(raise);
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_done_cyc"}, done_cyc, l + 2);
        chk({tag, "_msr_wd"}, msr_v, m_srr1);
        chk({tag, "_msr_cyc"}, msr_cyc, l + 1);
        chk({tag, "_npc"}, npc_v, m_srr0 & 32'hFFFF_FFFC);
        chk({tag, "_npc_cyc"}, npc_cyc, l + 2);
        chk({tag, "_no_spr_wr"}, wq.size(), 0);
        chk({tag, "_no_ack"}, ack_n, 0);
        chk({tag, "_flush_n"}, flush_n, l);
        @(posedge clk); #1;
        excep_code = 4'd0; rfi_req = 1'b0;
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(rfi_done), 32'd0);
        chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic preset(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    function automatic logic all_zero();
        return ~|{spr_raddr, spr_waddr, spr_wd, spr_wr, msr_wr, msr_wd, flush, stall,
                  npc_valid, npc, ack, rfi_done, busy};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        excep_code = '0; intr_entry_addr = '0; excep_pc = '0; data_ea = '0;
        msr_in = '0; rfi_req = 1'b0; pipe_drained = 1'b0;
        m_srr0 = '0; m_srr1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", 32'(all_zero()), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_not_busy", 32'(busy), 32'd0);

        run_exc("sc", 4'd8, 32'h0000_1000, 32'h1234_5678, 32'h0000_C000, 0, 1'b0);
        post_idle("sc");
        run_exc("dsi", 4'd1, 32'h0000_0200, 32'hDEAD_BEE0, 32'h0001_C030, 1, 1'b0);
        post_idle("dsi");
        run_exc("sc_wrap", 4'd8, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
        post_idle("sc_wrap");
        run_exc("drain_timeout", 4'd2, 32'h0000_4000, 32'h0, 32'h0000_0030, 1000, 1'b0);
        post_idle("drain_timeout");
        run_exc("drain_at3", 4'd3, 32'h0000_5000, 32'h0000_6000, 32'h0000_8010, 3, 1'b0);
        post_idle("drain_at3");

        preset(10'd27, 32'h0000_8000);
        preset(10'd26, 32'h0000_3003);
        m_srr1 = 32'h0000_8000; m_srr0 = 32'h0000_3003;
        run_rfi("rfi_dir", 0);
        run_rfi("rfi_slow", 6);

        run_exc("both", 4'd5, 32'h0000_7000, 32'h0, 32'h0000_4000, 0, 1'b1);
        run_rfi("both_rfi", 0);

        // Reset pulled in SV_SRR1 (cycle 3 with an immediate drain).
        clear_rec();
        for (int c = 0; c < 4; c++) exc_cycle(c, 4'd2, 32'h0000_9000, 32'h0, 32'h0000_C000, 0, 1'b0);
        chk("rst_mid_in_srr1", 32'({spr_wr, spr_waddr}), 32'({1'b1, 10'd27}));
        #2 rst = 1'b0;
        #1 chk("rst_mid_async_zero", 32'(all_zero()), 32'd1);
        @(posedge clk); #1;
        excep_code = 4'd0;
        chk("rst_mid_no_msr_wr", 32'(msr_wr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_release_idle", 32'({busy, msr_wr, spr_wr}), 32'd0);
        end
        chk("rst_mid_no_msr_write", msr_n, 0);

        for (int k = 0; k < 12; k++) begin
            logic [3:0] code;
            code = 4'($urandom_range(1, 10));
            run_exc($sformatf("rnd%0d", k), code, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 18)), 1'b0);
            post_idle($sformatf("rnd%0d", k));
            run_rfi($sformatf("rnd%0d_rfi", k), int'($urandom_range(0, 18)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
